// File: rtl/verificador_de_paridade.sv
// Serial frame receiver: start bit, N_BITS data bits LSB first, parity bit, stop bit.
// Checks even parity by default; defining PARIDADE_IMPAR_EN switches to odd parity.
module verificador_de_paridade #(
    parameter int N_BITS = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_in,
    input  logic              bit_en,
    output logic [N_BITS-1:0] D_out,
    output logic              word_valid,
    output logic              erro_paridade,
    output logic              erro_quadro,
    output logic [CNT_W-1:0]  cont_erros,
    output logic              ocupado
);

    localparam int IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam logic [IDX_W-1:0] IDX_ULT = IDX_W'(N_BITS - 1);

    typedef enum logic [1:0] {IDLE, DADOS, PARIDADE, PARADA} estado_t;

    estado_t           estado;
    logic [N_BITS-1:0] shreg;
    logic [IDX_W-1:0]  idx;
    logic              par_run;
    logic              erro_calc;
    logic              erro_bit;
    logic              cnt_sat;

    // Mismatch between the running data XOR and the parity bit on the line.
`ifdef PARIDADE_IMPAR_EN
    assign erro_bit = ~(par_run ^ bit_in);
`else
    assign erro_bit = par_run ^ bit_in;
`endif

    assign cnt_sat = &cont_erros;
    assign ocupado = (estado != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado        <= IDLE;
            shreg         <= '0;
            idx           <= '0;
            par_run       <= 1'b0;
            erro_calc     <= 1'b0;
            D_out         <= '0;
            word_valid    <= 1'b0;
            erro_paridade <= 1'b0;
            erro_quadro   <= 1'b0;
            cont_erros    <= '0;
        end else begin
            word_valid  <= 1'b0;
            erro_quadro <= 1'b0;
            if (bit_en) begin
                unique case (estado)
                    IDLE: begin
                        if (!bit_in) begin
                            estado  <= DADOS;
                            idx     <= '0;
                            shreg   <= '0;
                            par_run <= 1'b0;
                        end
                    end
                    DADOS: begin
                        shreg[idx] <= bit_in;
                        par_run    <= par_run ^ bit_in;
                        if (idx == IDX_ULT) estado <= PARIDADE;
                        else                idx    <= idx + IDX_W'(1);
                    end
                    PARIDADE: begin
                        erro_calc <= erro_bit;
                        estado    <= PARADA;
                    end
                    PARADA: begin
                        // A bad stop bit discards the word and counts only as a framing error.
                        if (bit_in) begin
                            D_out         <= shreg;
                            erro_paridade <= erro_calc;
                            word_valid    <= 1'b1;
                            if (erro_calc && !cnt_sat) cont_erros <= cont_erros + CNT_W'(1);
                        end else begin
                            erro_quadro <= 1'b1;
                            if (!cnt_sat) cont_erros <= cont_erros + CNT_W'(1);
                        end
                        estado <= IDLE;
                    end
                    default: estado <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_verificador_de_paridade.sv
// Directed bench for verificador_de_paridade: frame-level reference model checked
// every cycle, plus literal expectations at the key points of each scenario.
module tb_verificador_de_paridade;

    localparam int N_BITS = 4;
    localparam int CNT_W  = 2;
`ifdef PARIDADE_IMPAR_EN
    localparam bit ODD = 1'b1;
`else
    localparam bit ODD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              bit_in = 1'b1;
    logic              bit_en = 1'b0;
    logic [N_BITS-1:0] D_out;
    logic              word_valid;
    logic              erro_paridade;
    logic              erro_quadro;
    logic [CNT_W-1:0]  cont_erros;
    logic              ocupado;

    int tests = 0;
    int fails = 0;

    verificador_de_paridade #(.N_BITS(N_BITS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_en(bit_en),
        .D_out(D_out), .word_valid(word_valid), .erro_paridade(erro_paridade),
        .erro_quadro(erro_quadro), .cont_erros(cont_erros), .ocupado(ocupado)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: collect sampled bits from the start bit and judge the frame once complete.
    logic        bits[$];
    int          exp_dout, exp_cnt;
    logic        exp_wv, exp_ep, exp_eq, exp_busy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bits.delete();
            exp_dout = 0; exp_cnt = 0;
            exp_wv = 0; exp_ep = 0; exp_eq = 0; exp_busy = 0;
        end else begin
            exp_wv = 0;
            exp_eq = 0;
            if (bit_en && !(bits.size() == 0 && bit_in)) bits.push_back(bit_in);
            if (bits.size() == N_BITS + 3) begin
                int d, ones;
                logic err;
                d = 0;
                for (int i = 0; i < N_BITS; i++) d += int'(bits[1+i]) << i;
                ones = $countones(d) + int'(bits[N_BITS+1]);
                err  = ODD ? (ones % 2 == 0) : (ones % 2 == 1);
                if (bits[N_BITS+2]) begin
                    exp_wv = 1; exp_dout = d; exp_ep = err;
                    if (err && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
                end else begin
                    exp_eq = 1;
                    if (exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
                end
                bits.delete();
            end
            exp_busy = (bits.size() != 0);
        end
    end

    always @(negedge clk) begin
        check("cmp_D_out", int'(D_out), exp_dout);
        check("cmp_word_valid", int'(word_valid), int'(exp_wv));
        check("cmp_erro_paridade", int'(erro_paridade), int'(exp_ep));
        check("cmp_erro_quadro", int'(erro_quadro), int'(exp_eq));
        check("cmp_cont_erros", int'(cont_erros), exp_cnt);
        check("cmp_ocupado", int'(ocupado), int'(exp_busy));
    end

    function automatic logic good_par(input logic [N_BITS-1:0] d);
        return ODD ? ~^d : ^d;
    endfunction

    task automatic idle(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic b);
        bit_en = 1'b1;
        bit_in = b;
        @(posedge clk);
        #1;
        bit_en = 1'b0;
        bit_in = 1'b1;
    endtask

    task automatic send_frame(input logic [N_BITS-1:0] d, input logic p, input logic s, input int gap);
        strobe(1'b0);
        idle(gap);
        for (int i = 0; i < N_BITS; i++) begin
            strobe(d[i]);
            idle(gap);
        end
        strobe(p);
        idle(gap);
        strobe(s);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_D_out", int'(D_out), 0);
        check("reset_cont", int'(cont_erros), 0);
        check("reset_ocupado", int'(ocupado), 0);
        rst_n = 1'b1;

        bit_en = 1'b1;
        bit_in = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        bit_en = 1'b0;
        check("idle_ocupado", int'(ocupado), 0);
        check("idle_word_valid", int'(word_valid), 0);

        send_frame(4'hB, good_par(4'hB), 1'b1, 0);
        check("good_D_out", int'(D_out), 'hB);
        check("good_word_valid", int'(word_valid), 1);
        check("good_erro_paridade", int'(erro_paridade), 0);
        check("good_cont", int'(cont_erros), 0);
        idle(1);
        check("good_pulse_width", int'(word_valid), 0);

        send_frame(4'h6, ~good_par(4'h6), 1'b1, 0);
        check("par_D_out", int'(D_out), 'h6);
        check("par_word_valid", int'(word_valid), 1);
        check("par_erro_paridade", int'(erro_paridade), 1);
        check("par_cont", int'(cont_erros), 1);
        idle(2);

        send_frame(4'h3, good_par(4'h3), 1'b0, 0);
        check("frm_erro_quadro", int'(erro_quadro), 1);
        check("frm_word_valid", int'(word_valid), 0);
        check("frm_D_out_held", int'(D_out), 'h6);
        check("frm_erro_paridade_held", int'(erro_paridade), 1);
        check("frm_cont", int'(cont_erros), 2);
        idle(1);
        check("frm_pulse_width", int'(erro_quadro), 0);

        send_frame(4'hA, good_par(4'hA), 1'b1, 2);
        check("gap_D_out", int'(D_out), 'hA);
        check("gap_word_valid", int'(word_valid), 1);
        check("gap_erro_paridade", int'(erro_paridade), 0);
        send_frame(4'h5, good_par(4'h5), 1'b1, 0);
        check("b2b_D_out", int'(D_out), 'h5);
        check("b2b_word_valid", int'(word_valid), 1);
        check("b2b_cont", int'(cont_erros), 2);
        idle(2);

        // Abort mid-frame with reset.
        strobe(1'b0);
        strobe(1'b1);
        strobe(1'b0);
        check("abort_busy_before", int'(ocupado), 1);
        rst_n = 1'b0;
        #1;
        check("abort_ocupado", int'(ocupado), 0);
        check("abort_cont", int'(cont_erros), 0);
        check("abort_D_out", int'(D_out), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
        check("abort_erro_quadro", int'(erro_quadro), 0);
        check("abort_word_valid", int'(word_valid), 0);

        for (int k = 0; k < 5; k++) begin
            send_frame(N_BITS'(k + 1), ~good_par(N_BITS'(k + 1)), 1'b1, 0);
            idle(1);
        end
        check("sat_cont", int'(cont_erros), 3);
        send_frame(4'h9, good_par(4'h9), 1'b0, 0);
        check("sat_cont_frm", int'(cont_erros), 3);
        idle(1);

`ifdef PARIDADE_IMPAR_EN
        send_frame(4'hB, 1'b0, 1'b1, 0);
`else
        send_frame(4'hB, 1'b1, 1'b1, 0);
`endif
        check("lit_B_erro_paridade", int'(erro_paridade), 0);
        check("lit_B_D_out", int'(D_out), 'hB);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
